// File: rtl/garbage_spawner.sv
// garbage_spawner: offers a new garbage position 0-3 after a programmable delay from a request.
// Latency: valid rises SPAWN_DELAY+2 edges after the edge that samples req in IDLE.
// Backpressure: the offer (pos/valid) is held until ready=1 at a rising edge; req is ignored while busy.
// Optional feature: define GARBAGE_NO_REPEAT_EN to avoid offering the previously accepted position.
module garbage_spawner #(
  parameter int         SPAWN_DELAY = 50000000,
  parameter logic [2:0] LAST_INIT   = 3'b111
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [4:0] rng,
  input  logic       req,
  input  logic       ready,
  output logic [2:0] pos,
  output logic       valid,
  output logic       busy,
  output logic [7:0] spawn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PICK  = 2'd2,
    OFFER = 2'd3
  } state_t;

  localparam logic [27:0] DELAY_LD = 28'(SPAWN_DELAY);
  localparam logic [2:0]  POS_NONE = 3'b111;

  state_t      state;
  logic [27:0] delay_cnt;
  logic [2:0]  pos_r;
  logic [2:0]  last;
  logic [1:0]  pick;

  // Only the two low rng bits select a position.
  logic unused_rng;
  assign unused_rng = ^rng[4:2];

  // Candidate position for the PICK edge; optionally steps past the previous position.
  always_comb begin
    pick = rng[1:0];
`ifdef GARBAGE_NO_REPEAT_EN
    if ({1'b0, rng[1:0]} == last) begin
      pick = rng[1:0] + 2'd1;
    end
`endif
  end

`ifndef GARBAGE_NO_REPEAT_EN
  // The previous-position register only influences the pick with repeat avoidance.
  logic unused_last;
  assign unused_last = ^last;
`endif

  // Control FSM with registered valid/busy/pos so no input reaches an output combinationally.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      delay_cnt   <= '0;
      pos_r       <= '0;
      last        <= LAST_INIT;
      spawn_count <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      pos         <= POS_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= WAIT;
            delay_cnt <= DELAY_LD;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          // Counter stops at zero and is never reloaded here, so it cannot wrap.
          if (delay_cnt == '0) begin
            state <= PICK;
          end else begin
            delay_cnt <= delay_cnt - 28'd1;
          end
        end
        PICK: begin
          // rng is sampled only on this edge; later rng changes cannot move the offer.
          pos_r <= {1'b0, pick};
          pos   <= {1'b0, pick};
          valid <= 1'b1;
          state <= OFFER;
        end
        OFFER: begin
          // Acceptance always returns to IDLE; a concurrent req is seen on the next edge.
          if (ready) begin
            last        <= pos_r;
            spawn_count <= spawn_count + 8'd1;
            valid       <= 1'b0;
            busy        <= 1'b0;
            pos         <= POS_NONE;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_garbage_spawner.sv
// Self-checking bench for garbage_spawner: randomized traffic against a transaction-level model.
// Main instance uses SPAWN_DELAY=4, a second instance uses SPAWN_DELAY=0.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_garbage_spawner;

  localparam int D = 4;

  logic       CLOCK_50;
  logic       reset_n;
  logic [4:0] rng;
  logic       req;
  logic       ready;
  logic [2:0] pos;
  logic       valid;
  logic       busy;
  logic [7:0] spawn_count;

  logic [4:0] rng2;
  logic       req2;
  logic       ready2;
  logic [2:0] pos2;
  logic       valid2;
  logic       busy2;
  logic [7:0] spawn_count2;

  int tests;
  int fails;

  // Model state: last accepted position (7 = none) and accepted count.
  int m_last;
  int m_count;

  garbage_spawner #(.SPAWN_DELAY(D)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .rng         (rng),
    .req         (req),
    .ready       (ready),
    .pos         (pos),
    .valid       (valid),
    .busy        (busy),
    .spawn_count (spawn_count)
  );

  garbage_spawner #(.SPAWN_DELAY(0)) dut0 (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .rng         (rng2),
    .req         (req2),
    .ready       (ready2),
    .pos         (pos2),
    .valid       (valid2),
    .busy        (busy2),
    .spawn_count (spawn_count2)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected offered position from the rng value present at the pick edge.
  function automatic int expect_pos(input logic [4:0] r);
    int c;
    c = int'(r) % 4;
`ifdef GARBAGE_NO_REPEAT_EN
    if (c == m_last) c = (c + 1) % 4;
`endif
    return c;
  endfunction

  // One full request/offer/accept transaction on the SPAWN_DELAY=4 instance.
  // chain=1 keeps req high through acceptance, so the next call's first edge starts a new request.
  task automatic do_spawn(input logic [4:0] r_pick, input int hold, input bit chain);
    int ep;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("busy_after_req", int'(busy), 1);
    check("valid_after_req", int'(valid), 0);
    check("pos_after_req", int'(pos), 7);
    // Random req/ready/rng noise while waiting; none of it may matter.
    for (int i = 0; i < D + 1; i++) begin
      req   = 1'($urandom);
      ready = 1'($urandom);
      rng   = 5'($urandom);
      tick();
      check("wait_valid", int'(valid), 0);
      check("wait_busy", int'(busy), 1);
    end
    ep    = expect_pos(r_pick);
    rng   = r_pick;
    req   = 1'($urandom);
    ready = 1'($urandom);
    tick();
    check("offer_valid", int'(valid), 1);
    check("offer_pos", int'(pos), ep);
    for (int i = 0; i < hold; i++) begin
      req   = 1'($urandom);
      ready = 1'b0;
      rng   = 5'($urandom);
      tick();
      check("hold_valid", int'(valid), 1);
      check("hold_pos", int'(pos), ep);
      check("hold_busy", int'(busy), 1);
    end
    ready = 1'b1;
    req   = chain;
    tick();
    ready   = 1'b0;
    req     = chain;
    m_last  = ep;
    m_count = (m_count + 1) % 256;
    check("accept_valid", int'(valid), 0);
    check("accept_pos", int'(pos), 7);
    check("accept_busy", int'(busy), 0);
    check("accept_count", int'(spawn_count), m_count);
  endtask

  initial begin
    int start_count;
    int ep0;
    tests   = 0;
    fails   = 0;
    m_last  = 7;
    m_count = 0;
    reset_n = 1'b0;
    rng     = 5'd0;
    req     = 1'b0;
    ready   = 1'b0;
    rng2    = 5'd0;
    req2    = 1'b0;
    ready2  = 1'b0;

    #22;
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pos", int'(pos), 7);
    check("rst_count", int'(spawn_count), 0);
    reset_n = 1'b1;
    tick();

    // Zero-delay instance: valid two edges after the sampling edge.
    req2 = 1'b1;
    rng2 = 5'($urandom);
    ep0  = int'(rng2) % 4;
    tick();
    req2 = 1'b0;
    check("d0_busy_k", int'(busy2), 1);
    check("d0_valid_k", int'(valid2), 0);
    tick();
    check("d0_valid_k1", int'(valid2), 0);
    tick();
    check("d0_valid_k2", int'(valid2), 1);
    check("d0_pos_k2", int'(pos2), ep0);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    check("d0_count", int'(spawn_count2), 1);
    check("d0_busy_done", int'(busy2), 0);

    // Directed first offer at pos 2 with a long hold, then a repeat request on the same rng.
    do_spawn(5'b00010, 10, 1'b0);
    do_spawn(5'b11110, 3, 1'b0);
`ifdef GARBAGE_NO_REPEAT_EN
    check("repeat_avoid_last", m_last, 3);
`else
    check("repeat_plain_last", m_last, 2);
`endif

    // Accept with req high: must drop to IDLE, then start on the following edge.
    do_spawn(5'($urandom), 2, 1'b1);
    do_spawn(5'($urandom), 0, 1'b0);

    // Reset mid-WAIT abandons the transaction asynchronously.
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", int'(valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(spawn_count), 0);
    check("midrst_pos", int'(pos), 7);
    m_last  = 7;
    m_count = 0;
    tick();
    reset_n = 1'b1;
    tick();

    // First edge after reset honours req; then a full wrap of the count.
    start_count = m_count;
    for (int n = 0; n < 256; n++) begin
      do_spawn(5'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end
    req = 1'b0;
    tick();
    check("wrap_count", int'(spawn_count), start_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
